boot_loader_ctrl: RTL

//  Hardware boot sequencer: on start, copies the boot image word-by-word from disk into instruction memory.

---
 rtl/iz_boot_pkg.sv | 25 ++
 rtl/boot_loader_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/iz_boot_pkg.sv
// Shared boot sequencer types: FSM state encoding, HALT opcode, opcode field slice.
// Latency: none, declarations only.
// Backpressure: not applicable.
`ifndef IZ_BOOT_PKG_SV
`define IZ_BOOT_PKG_SV

// Opcode field of a 32-bit instruction word; only these bits decide HALT.
`define IZ_OPC_FIELD(w) w[31:26]

package iz_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } boot_state_e;

    // Opcode that marks the last word of a boot image.
    localparam logic [5:0] BOOT_HALT_OPC = 6'b011000;

endpackage

`endif

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: copies the disk boot image into instruction memory up to and including the HALT word.
// Latency: 2 cycles per word (FETCH + WRITE) plus one cycle per disk wait cycle.
// Backpressure: disk_rd_req held with a stable address until disk_rd_valid; the core is stalled throughout.
module boot_loader_ctrl
    import iz_boot_pkg::*;
#(
    parameter int                ADDR_W    = 26,
    parameter int                DATA_W    = 32,
    parameter int                MAX_WORDS = 1024,
    parameter logic [5:0]        HALT_OPC  = BOOT_HALT_OPC,
    parameter logic [ADDR_W-1:0] DISK_BASE = '0,
    parameter logic [ADDR_W-1:0] IM_BASE   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              disk_rd_req,
    output logic [ADDR_W-1:0] disk_addr,
    input  logic              disk_rd_valid,
    input  logic [DATA_W-1:0] disk_rd_data,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              boot_done,
    output logic              boot_err,
    output logic [ADDR_W-1:0] mmu_lower
);

    // One extra bit so the counter can represent MAX_WORDS itself.
    localparam int CNT_W = $clog2(MAX_WORDS) + 1;

    boot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] mmu_lower_q, mmu_lower_d;
    logic              halt_word;

    assign halt_word = (`IZ_OPC_FIELD(data_q) == HALT_OPC);

    // State, word counter, captured disk word and published image length.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            mmu_lower_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            mmu_lower_q <= mmu_lower_d;
        end
    end

    // Next-state logic; start is only honoured when no copy is in flight.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        mmu_lower_d = mmu_lower_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (disk_rd_valid) begin
                    data_d  = disk_rd_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (halt_word) begin
                    state_d     = ST_DONE;
                    mmu_lower_d = ADDR_W'(cnt_q) + ADDR_W'(1);
                end else if (cnt_q == CNT_W'(MAX_WORDS - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state, so they never follow inputs combinationally.
    // Addresses and data are forced to zero outside their strobes so reset shows all-zero outputs.
    always_comb begin
        disk_rd_req = 1'b0;
        disk_addr   = '0;
        im_we       = 1'b0;
        im_addr     = '0;
        im_wdata    = '0;
        cpu_hold    = 1'b0;
        boot_done   = 1'b0;
        boot_err    = 1'b0;
        mmu_lower   = mmu_lower_q;
        case (state_q)
            ST_FETCH: begin
                disk_rd_req = 1'b1;
                disk_addr   = DISK_BASE + ADDR_W'(cnt_q);
                cpu_hold    = 1'b1;
            end
            ST_WRITE: begin
                im_we    = 1'b1;
                im_addr  = IM_BASE + ADDR_W'(cnt_q);
                im_wdata = data_q;
                cpu_hold = 1'b1;
            end
            ST_DONE: boot_done = 1'b1;
            ST_ERR:  boot_err  = 1'b1;
            default: ;
        endcase
    end

endmodule
